// File: rtl/gray_codec.sv
// Two-stage valid/ready binary<->gray converter; each word carries its own mode bit.
// Optional single-bit-step monitor on mode-0 outputs is enabled by defining GRAY_CODEC_STEP_CHECK_EN.
module gray_codec #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_mode,
    output logic         out_step
);

    typedef enum logic {
        MODE_B2G = 1'b0,
        MODE_G2B = 1'b1
    } mode_e;

    typedef struct packed {
        logic [N-1:0] data;
        mode_e        mode;
    } word_t;

    word_t s1, s2;
    logic  s1_valid, s2_valid;
    logic  s2_adv;

    // Both directions share the MSB; below it, b2g XORs neighbouring inputs while
    // g2b XORs with the already-decoded bit above (the prefix-XOR chain).
    function automatic logic [N-1:0] convert(input logic [N-1:0] d, input mode_e m);
        logic [N-1:0] r;
        r[N-1] = d[N-1];
        for (int i = N - 2; i >= 0; i--) begin
            r[i] = (m == MODE_B2G) ? (d[i+1] ^ d[i]) : (r[i+1] ^ d[i]);
        end
        return r;
    endfunction

    assign s2_adv   = !s2_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;

    // NOTE: state registers use non-blocking assignment so every stage samples
    // the pre-edge value of the stage before it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            // NOTE: only S2's payload is reset because it is directly visible on the
            // outputs; S1's payload is never used while S1 is invalid.
            s2       <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1 <= '{data: in_data, mode: mode_e'(in_mode)};
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2 <= '{data: convert(s1.data, s1.mode), mode: s1.mode};
                end
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2.data;
    assign out_mode  = s2.mode;

`ifdef GRAY_CODEC_STEP_CHECK_EN
    logic [N-1:0] hist;
    logic         hist_valid;
    logic [N-1:0] diff;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_valid <= 1'b0;
        end else if (out_valid && out_ready && s2.mode == MODE_B2G) begin
            hist_valid <= 1'b1;
        end
    end

    // History payload only matters once hist_valid is set.
    always_ff @(posedge clk) begin
        if (out_valid && out_ready && s2.mode == MODE_B2G) begin
            hist <= s2.data;
        end
    end

    assign diff     = s2.data ^ hist;
    assign out_step = hist_valid && (s2.mode == MODE_B2G) && ($countones(diff) == 1);
`else
    assign out_step = 1'b0;
`endif

endmodule

// File: tb/tb_gray_codec.sv
// Directed and scoreboarded bench for gray_codec (N=8); step expectations follow
// whether GRAY_CODEC_STEP_CHECK_EN is defined.
module tb_gray_codec;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         out_mode;
    logic         out_step;

    gray_codec #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode),
        .out_step  (out_step)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] data;
        logic         mode;
    } word_t;

    int           total = 0;
    int           bad   = 0;
    word_t        stim_q[$];
    word_t        exp_q[$];
    logic [N-1:0] hist;
    bit           hist_valid = 1'b0;
    int           step_ones;
    int           acc;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference: b2g is b ^ (b >> 1); g2b is the log-step shift-XOR prefix.
    function automatic logic [N-1:0] ref_conv(input logic [N-1:0] d, input logic m);
        logic [N-1:0] r;
        if (!m) return d ^ (d >> 1);
        r = d;
        for (int s = 1; s < N; s = s * 2) r = r ^ (r >> s);
        return r;
    endfunction

    function automatic bit ref_step(input logic [N-1:0] d, input logic m);
`ifdef GRAY_CODEC_STEP_CHECK_EN
        return !m && hist_valid && ($countones(d ^ hist) == 1);
`else
        return 1'b0;
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        hist_valid = 1'b0;
        exp_q.delete();
    endtask

    task automatic run_stream(input bit throttle, input int max_cycles);
        int    cyc = 0;
        bit    offering = 1'b0;
        word_t cur;
        word_t e;
        cur.data = '0; cur.mode = 1'b0;
        while ((stim_q.size() != 0 || offering || exp_q.size() != 0) && cyc < max_cycles) begin
            @(negedge clk);
            cyc++;
            if (!offering && stim_q.size() != 0 && (!throttle || $urandom_range(0, 9) < 7)) begin
                cur = stim_q.pop_front();
                offering = 1'b1;
            end
            in_valid  = offering;
            in_data   = cur.data;
            in_mode   = cur.mode;
            out_ready = !throttle || ($urandom_range(0, 9) < 6);
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_spurious_word", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data", out_data, e.data);
                    check("sb_mode", out_mode, e.mode);
                    check("sb_step", out_step, ref_step(e.data, e.mode));
                    if (out_step) step_ones++;
                    if (!e.mode) begin
                        hist = e.data;
                        hist_valid = 1'b1;
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back('{ref_conv(cur.data, cur.mode), cur.mode});
                offering = 1'b0;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("sb_drained", stim_q.size() + exp_q.size() + int'(offering), 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_mode", out_mode, 0);
        check("rst_out_step", out_step, 0);
        check("rst_in_ready", in_ready, 1);

        // b2g 0x05 -> 0x07, two cycles after acceptance
        @(negedge clk); in_valid = 1'b1; in_data = 8'h05; in_mode = 1'b0; out_ready = 1'b1;
        #1 check("b2g_accept", in_ready, 1);
        @(negedge clk); in_valid = 1'b0;
        #1 check("b2g_lat1_valid", out_valid, 0);
        @(negedge clk);
        #1;
        check("b2g_lat2_valid", out_valid, 1);
        check("b2g_data", out_data, 8'h07);
        check("b2g_mode", out_mode, 0);
        @(negedge clk);
        #1 check("b2g_drained", out_valid, 0);

        // g2b 0x07, 0x80 back-to-back -> 0x05, 0xFF
        @(negedge clk); in_valid = 1'b1; in_data = 8'h07; in_mode = 1'b1;
        #1 check("g2b_accept0", in_ready, 1);
        @(negedge clk); in_data = 8'h80;
        #1 check("g2b_accept1", in_ready, 1);
        @(negedge clk); in_valid = 1'b0;
        #1;
        check("g2b_valid0", out_valid, 1);
        check("g2b_data0", out_data, 8'h05);
        check("g2b_mode0", out_mode, 1);
        @(negedge clk);
        #1;
        check("g2b_valid1", out_valid, 1);
        check("g2b_data1", out_data, 8'hFF);
        check("g2b_mode1", out_mode, 1);
        @(negedge clk);
        #1 check("g2b_drained", out_valid, 0);

        // backpressure: 4 cycles of out_ready=0 with in_valid=1
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            in_valid = 1'b1; in_mode = 1'b0; out_ready = 1'b0;
            in_data = (acc == 0) ? 8'h10 : (acc == 1) ? 8'h11 : 8'h12;
            #1;
            if (c >= 2) begin
                check("bp_in_ready_low", in_ready, 0);
                check("bp_out_valid", out_valid, 1);
                check("bp_out_held", out_data, 8'h18);
            end
            if (in_valid && in_ready) acc++;
        end
        check("bp_accept_count", acc, 2);
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check("bp_rel_valid0", out_valid, 1);
        check("bp_rel_data0", out_data, 8'h18);
        @(negedge clk);
        #1;
        check("bp_rel_valid1", out_valid, 1);
        check("bp_rel_data1", out_data, 8'h19);
        @(negedge clk);
        #1 check("bp_rel_drained", out_valid, 0);

        // reset with both stages full
        @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hAA; in_mode = 1'b0;
        @(negedge clk); in_data = 8'h55;
        @(negedge clk); in_valid = 1'b0;
        #1;
        check("rstmid_full_valid", out_valid, 1);
        check("rstmid_full_ready", in_ready, 0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1;
        check("rstmid_out_valid", out_valid, 0);
        check("rstmid_in_ready", in_ready, 1);
        check("rstmid_out_data", out_data, 0);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1 check("rstmid_no_stale", out_valid, 0);
        end

        // mode-0 sweep with one mode-1 word interleaved
        do_reset();
        step_ones = 0;
        for (int v = 0; v < 256; v++) begin
            stim_q.push_back('{v[N-1:0], 1'b0});
            if (v == 8'h80) stim_q.push_back('{8'h3C, 1'b1});
        end
        run_stream(1'b0, 600);
`ifdef GRAY_CODEC_STEP_CHECK_EN
        check("sweep_step_count", step_ones, 255);
`else
        check("sweep_step_count", step_ones, 0);
`endif

        // random throttling, mixed modes
        for (int w = 0; w < 10000; w++) begin
            stim_q.push_back('{N'($urandom), 1'($urandom)});
        end
        run_stream(1'b1, 40000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
